sound_mem_arbiter: RTL and testbench

Sequences the single sound-RAM SDRAM client port between the GLU sound-RAM write path and the DOC5503 wavetable fetch path. GLU bus writes are non-stallable one-cycle strobes, so they are absorbed into a small write FIFO. DOC wave reads get priority, except when that FIFO is full. Sits inside the sound block, between the GLU register logic, the DOC, and one SDRAM port.

---
 rtl/sound_mem_pkg.sv | 34 +++
 rtl/sound_wr_fifo.sv | 77 +++++++
 rtl/sound_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_sound_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_mem_pkg.sv
// ---------------------------------------------------------------------------
// sound_mem_pkg
// Shared types and constants for the sound-RAM arbiter.
//   sound_mem_state_t         : arbiter state machine encoding
//   SOUND_MEM_BASE            : upper 7 bits of the 21-bit SDRAM word address
//   SOUND_MEM_TIMEOUT_DEFAULT : default wait budget before abandoning a transaction
//   sound_wr_entry_t          : one queued GLU write {addr, data}
//   lane_mask()               : one-hot byte enable for a byte lane
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package sound_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } sound_mem_state_t;

    // Sound RAM sits at byte 0x4_0000, i.e. word address 0x1_0000.
    localparam logic [6:0] SOUND_MEM_BASE = 7'b0000100;

    localparam int SOUND_MEM_TIMEOUT_DEFAULT = 255;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } sound_wr_entry_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/sound_wr_fifo.sv
// ---------------------------------------------------------------------------
// sound_wr_fifo
// Small synchronous FIFO that absorbs non-stallable GLU write strobes.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_data : write side; ignored when full unless popped the same cycle
//   i_pop, o_data  : read side; o_data is the current head (valid when !o_empty)
//   o_full, o_empty, o_count : registered occupancy after this cycle's push/pop
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sound_wr_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [23:0]
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  T                         i_data,
    input  logic                     i_pop,
    output T                         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_full;
    logic           r_empty;

    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_count_next;

    // A pop frees the slot a simultaneous push needs, so push-while-full is
    // accepted whenever the head leaves in the same cycle.
    assign w_pop  = i_pop && !r_empty;
    assign w_push = i_push && (!r_full || w_pop);

    always_comb begin
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Storage has no reset; only pointers and flags define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/sound_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sound_mem_arbiter
// Shares one SDRAM client port between GLU sound-RAM writes (queued in a
// write FIFO) and DOC5503 wavetable reads (one pending request register).
// Reads win unless the write FIFO is full. One transaction outstanding.
//   clk_logic, system_reset_n      : clock, synchronous active-low reset
//   glu_wr_i/addr/data             : one-cycle write strobe into the FIFO
//   glu_full_o, glu_drop_o         : FIFO full flag, dropped-write pulse
//   doc_rd_i/addr, doc_data_o/ready: wave fetch request and byte response
//   mem_*                          : SDRAM port (issue pulses, word address,
//                                    replicated write data, byte enables,
//                                    read word, completion pulse)
//   timeout_cnt_o                  : saturating count of abandoned transactions
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sound_mem_arbiter
    import sound_mem_pkg::*;
#(
    parameter int         WFIFO_DEPTH    = 4,
    parameter int         TIMEOUT_CYCLES = SOUND_MEM_TIMEOUT_DEFAULT,
    parameter logic [6:0] MEM_BASE       = SOUND_MEM_BASE
) (
    input  logic         clk_logic,
    input  logic         system_reset_n,
    input  logic         glu_wr_i,
    input  logic [15:0]  glu_addr_i,
    input  logic [7:0]   glu_data_i,
    output logic         glu_full_o,
    output logic         glu_drop_o,
    input  logic         doc_rd_i,
    input  logic [15:0]  doc_addr_i,
    output logic [7:0]   doc_data_o,
    output logic         doc_ready_o,
    output logic [20:0]  mem_addr_o,
    output logic         mem_rd_o,
    output logic         mem_wr_o,
    output logic [31:0]  mem_data_o,
    output logic [3:0]   mem_byte_en_o,
    input  logic [31:0]  mem_q_i,
    input  logic         mem_ready_i,
    output logic [7:0]   timeout_cnt_o
);

    localparam int CNT_W  = $clog2(WFIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------- registers ----------------
    sound_mem_state_t r_state;
    logic             r_rd_pend;
    logic [15:0]      r_rd_addr;
    logic [1:0]       r_lane;
    logic [20:0]      r_mem_addr;
    logic [31:0]      r_mem_data;
    logic [3:0]       r_mem_be;
    logic             r_mem_rd;
    logic             r_mem_wr;
    logic [7:0]       r_doc_data;
    logic             r_doc_ready;
    logic             r_drop;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [7:0]       r_tmo_cnt;

    // ---------------- wires ----------------
    sound_wr_entry_t  w_push_entry;
    sound_wr_entry_t  w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_at_cap;
    logic             w_idle;
    logic             w_rd_pending;
    logic [15:0]      w_rd_addr;
    logic             w_issue_rd;
    logic             w_issue_wr;
    logic             w_ready_ok;
    logic             w_wait_done;
    logic             w_drop;
    logic [7:0]       w_q_lane;

    assign w_push_entry.addr = glu_addr_i;
    assign w_push_entry.data = glu_data_i;

    sound_wr_fifo #(
        .DEPTH (WFIFO_DEPTH),
        .T     (sound_wr_entry_t)
    ) u_wr_fifo (
        .i_clk   (clk_logic),
        .i_rst_n (system_reset_n),
        .i_push  (glu_wr_i),
        .i_data  (w_push_entry),
        .i_pop   (w_issue_wr),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_fifo_at_cap = (w_fifo_count == CNT_W'(WFIFO_DEPTH));
    assign w_idle        = (r_state == ST_IDLE);

    // A request arriving while idle is issued straight from the port, which
    // gives the single-cycle doc_rd_i -> mem_rd_o path. An already pending
    // request is older and goes first; the new one then stays pending.
    assign w_rd_pending = r_rd_pend | doc_rd_i;
    assign w_rd_addr    = r_rd_pend ? r_rd_addr : doc_addr_i;

    // A full FIFO can lose GLU writes, so it outranks the DOC.
    assign w_issue_wr = w_idle && !w_fifo_empty && (w_fifo_at_cap || !w_rd_pending);
    assign w_issue_rd = w_idle && w_rd_pending && !w_fifo_at_cap;

    // Completion in the issue cycle itself is not legal and is ignored.
    assign w_ready_ok  = mem_ready_i && !(r_mem_rd || r_mem_wr);
    assign w_wait_done = (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    assign w_drop   = glu_wr_i && w_fifo_full && !w_issue_wr;
    assign w_q_lane = mem_q_i[{r_lane, 3'b000} +: 8];

    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            r_state     <= ST_IDLE;
            r_rd_pend   <= 1'b0;
            r_rd_addr   <= '0;
            r_lane      <= '0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_be    <= 4'b1111;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_doc_data  <= '0;
            r_doc_ready <= 1'b0;
            r_drop      <= 1'b0;
            r_wait_cnt  <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_doc_ready <= 1'b0;
            r_drop      <= w_drop;

            // Request register: a fresh doc_rd_i outlives a same-cycle issue.
            if (w_issue_rd) begin
                r_rd_pend <= doc_rd_i && r_rd_pend;
            end else if (doc_rd_i) begin
                r_rd_pend <= 1'b1;
            end
            if (doc_rd_i) begin
                r_rd_addr <= doc_addr_i;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_issue_wr) begin
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= {MEM_BASE, w_head.addr[15:2]};
                        r_mem_data <= {4{w_head.data}};
                        r_mem_be   <= lane_mask(w_head.addr[1:0]);
                        r_wait_cnt <= '0;
                        r_state    <= ST_WR_WAIT;
                    end else if (w_issue_rd) begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= {MEM_BASE, w_rd_addr[15:2]};
                        r_mem_be   <= 4'b1111;
                        r_lane     <= w_rd_addr[1:0];
                        r_wait_cnt <= '0;
                        r_state    <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (w_ready_ok) begin
                        r_doc_data  <= w_q_lane;
                        r_doc_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_wait_done) begin
                        // Midscale keeps the DOC output silent-ish on a lost fetch.
                        r_doc_data  <= 8'h80;
                        r_doc_ready <= 1'b1;
                        if (r_tmo_cnt != 8'hFF) r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end

                ST_WR_WAIT: begin
                    if (w_ready_ok) begin
                        r_state <= ST_IDLE;
                    end else if (w_wait_done) begin
                        if (r_tmo_cnt != 8'hFF) r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign glu_full_o    = w_fifo_full;
    assign glu_drop_o    = r_drop;
    assign doc_data_o    = r_doc_data;
    assign doc_ready_o   = r_doc_ready;
    assign mem_addr_o    = r_mem_addr;
    assign mem_rd_o      = r_mem_rd;
    assign mem_wr_o      = r_mem_wr;
    assign mem_data_o    = r_mem_data;
    assign mem_byte_en_o = r_mem_be;
    assign timeout_cnt_o = r_tmo_cnt;

endmodule

// File: tb/tb_sound_mem_arbiter.sv
`timescale 1ns/1ps

module tb_sound_mem_arbiter;

    logic         clk_logic = 1'b0;
    logic         system_reset_n;
    logic         glu_wr_i;
    logic [15:0]  glu_addr_i;
    logic [7:0]   glu_data_i;
    logic         glu_full_o;
    logic         glu_drop_o;
    logic         doc_rd_i;
    logic [15:0]  doc_addr_i;
    logic [7:0]   doc_data_o;
    logic         doc_ready_o;
    logic [20:0]  mem_addr_o;
    logic         mem_rd_o;
    logic         mem_wr_o;
    logic [31:0]  mem_data_o;
    logic [3:0]   mem_byte_en_o;
    logic [31:0]  mem_q_i;
    logic         mem_ready_i;
    logic [7:0]   timeout_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    sound_mem_arbiter #(
        .WFIFO_DEPTH    (4),
        .TIMEOUT_CYCLES (255),
        .MEM_BASE       (7'b0000100)
    ) dut (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .glu_wr_i       (glu_wr_i),
        .glu_addr_i     (glu_addr_i),
        .glu_data_i     (glu_data_i),
        .glu_full_o     (glu_full_o),
        .glu_drop_o     (glu_drop_o),
        .doc_rd_i       (doc_rd_i),
        .doc_addr_i     (doc_addr_i),
        .doc_data_o     (doc_data_o),
        .doc_ready_o    (doc_ready_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rd_o       (mem_rd_o),
        .mem_wr_o       (mem_wr_o),
        .mem_data_o     (mem_data_o),
        .mem_byte_en_o  (mem_byte_en_o),
        .mem_q_i        (mem_q_i),
        .mem_ready_i    (mem_ready_i),
        .timeout_cnt_o  (timeout_cnt_o)
    );

    always #5 clk_logic = ~clk_logic;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_logic);
        #1;
    endtask

    // Drive a completion pulse after 'delay' further cycles; leaves the bench
    // in the cycle after the pulse.
    task automatic mem_ack(input int delay, input logic [31:0] q);
        repeat (delay) tick();
        mem_q_i     = q;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
    endtask

    // Bounded wait for the next issue pulse.
    task automatic wait_issue(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_rd_o || mem_wr_o) begin
                got = 1'b1;
                $display("issue %s addr=%h data=%h be=%b", mem_rd_o ? "RD" : "WR",
                         mem_addr_o, mem_data_o, mem_byte_en_o);
                break;
            end
        end
    endtask

    task automatic test_reset();
        system_reset_n = 1'b0;
        glu_wr_i = 1'b0; glu_addr_i = '0; glu_data_i = '0;
        doc_rd_i = 1'b0; doc_addr_i = '0;
        mem_q_i = '0; mem_ready_i = 1'b0;
        repeat (3) tick();
        n_cmp++; if (mem_byte_en_o !== 4'b1111) begin n_err++; $display("FAIL reset_be: got %b want 1111", mem_byte_en_o); end
        n_cmp++; if (mem_addr_o !== 21'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
        n_cmp++; if ({mem_rd_o, mem_wr_o, doc_ready_o, glu_full_o, glu_drop_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000", {mem_rd_o, mem_wr_o, doc_ready_o, glu_full_o, glu_drop_o}); end
        n_cmp++; if ({mem_data_o, doc_data_o, timeout_cnt_o} !== 48'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {mem_data_o, doc_data_o, timeout_cnt_o}); end
        system_reset_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_read();
        doc_rd_i = 1'b1; doc_addr_i = 16'h1235;
        tick();
        doc_rd_i = 1'b0;
        n_cmp++; if (mem_rd_o !== 1'b1) begin n_err++; $display("FAIL rd_latency: mem_rd_o got %b want 1", mem_rd_o); end
        n_cmp++; if (mem_addr_o !== 21'h1048D) begin n_err++; $display("FAIL rd_addr: got %h want 1048d", mem_addr_o); end
        n_cmp++; if (mem_byte_en_o !== 4'hF) begin n_err++; $display("FAIL rd_be: got %b want 1111", mem_byte_en_o); end
        repeat (3) tick();
        n_cmp++; if (doc_ready_o !== 1'b0) begin n_err++; $display("FAIL rd_early_ready: got %b want 0", doc_ready_o); end
        mem_q_i = 32'hDDCCBBAA; mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        n_cmp++; if (doc_ready_o !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %b want 1", doc_ready_o); end
        n_cmp++; if (doc_data_o !== 8'hBB) begin n_err++; $display("FAIL rd_data: got %h want bb", doc_data_o); end
        $display("read addr=1235 -> data=%h", doc_data_o);
        tick();
        n_cmp++; if (doc_ready_o !== 1'b0) begin n_err++; $display("FAIL rd_ready_pulse: got %b want 0", doc_ready_o); end
    endtask

    task automatic test_write();
        glu_wr_i = 1'b1; glu_addr_i = 16'h0003; glu_data_i = 8'h5A;
        tick();
        glu_wr_i = 1'b0;
        n_cmp++; if (mem_wr_o !== 1'b0) begin n_err++; $display("FAIL wr_latency1: mem_wr_o got %b want 0", mem_wr_o); end
        tick();
        n_cmp++; if (mem_wr_o !== 1'b1) begin n_err++; $display("FAIL wr_latency2: mem_wr_o got %b want 1", mem_wr_o); end
        n_cmp++; if (mem_data_o !== 32'h5A5A5A5A) begin n_err++; $display("FAIL wr_data: got %h want 5a5a5a5a", mem_data_o); end
        n_cmp++; if (mem_byte_en_o !== 4'b1000) begin n_err++; $display("FAIL wr_be: got %b want 1000", mem_byte_en_o); end
        n_cmp++; if (mem_addr_o !== 21'h10000) begin n_err++; $display("FAIL wr_addr: got %h want 10000", mem_addr_o); end
        $display("write addr=0003 data=5a issued");
        mem_ack(2, 32'h0);
    endtask

    task automatic test_order();
        bit got;
        // W0 keeps the port busy while a read and two writes queue up.
        glu_wr_i = 1'b1; glu_addr_i = 16'h0010; glu_data_i = 8'h11;
        tick();
        glu_wr_i = 1'b0;
        tick();
        n_cmp++; if (mem_wr_o !== 1'b1) begin n_err++; $display("FAIL ord_w0: mem_wr_o got %b want 1", mem_wr_o); end
        glu_wr_i = 1'b1; glu_addr_i = 16'h0021; glu_data_i = 8'h22;
        tick();
        glu_addr_i = 16'h0032; glu_data_i = 8'h33;
        doc_rd_i = 1'b1; doc_addr_i = 16'h0100;
        tick();
        glu_wr_i = 1'b0; doc_rd_i = 1'b0;
        mem_ack(1, 32'h0);

        wait_issue(got);
        n_cmp++; if (!got) begin n_err++; $display("FAIL ord_first_timeout: got none want read"); end
        n_cmp++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 21'h10040) begin
            n_err++; $display("FAIL ord_first: got rd=%b addr=%h want rd=1 addr=10040", mem_rd_o, mem_addr_o); end
        mem_ack(1, 32'h0);

        wait_issue(got);
        n_cmp++; if (!got || mem_wr_o !== 1'b1 || mem_addr_o !== 21'h10008 || mem_data_o !== 32'h22222222 || mem_byte_en_o !== 4'b0010) begin
            n_err++; $display("FAIL ord_second: got wr=%b addr=%h data=%h be=%b want wr=1 addr=10008 data=22222222 be=0010",
                              mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o); end
        mem_ack(1, 32'h0);

        wait_issue(got);
        n_cmp++; if (!got || mem_wr_o !== 1'b1 || mem_addr_o !== 21'h1000C || mem_data_o !== 32'h33333333 || mem_byte_en_o !== 4'b0100) begin
            n_err++; $display("FAIL ord_third: got wr=%b addr=%h data=%h be=%b want wr=1 addr=1000c data=33333333 be=0100",
                              mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o); end
        mem_ack(1, 32'h0);
    endtask

    task automatic test_full();
        bit got;
        int extra;
        logic [20:0] addr_tab [3];
        logic [3:0]  be_tab   [3];
        addr_tab = '{21'h10010, 21'h10010, 21'h10011};
        be_tab   = '{4'b0100, 4'b1000, 4'b0001};

        for (int i = 0; i < 5; i++) begin
            glu_wr_i = 1'b1; glu_addr_i = 16'h0040 + 16'(i); glu_data_i = 8'hA0 + 8'(i);
            tick();
            glu_wr_i = 1'b0;
            tick();
        end
        n_cmp++; if (glu_full_o !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", glu_full_o); end
        n_cmp++; if (glu_drop_o !== 1'b0) begin n_err++; $display("FAIL full_nodrop: got %b want 0", glu_drop_o); end

        glu_wr_i = 1'b1; glu_addr_i = 16'h0045; glu_data_i = 8'hA5;
        tick();
        glu_wr_i = 1'b0;
        n_cmp++; if (glu_drop_o !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b want 1", glu_drop_o); end
        $display("write addr=0045 dropped=%b", glu_drop_o);
        tick();
        n_cmp++; if (glu_drop_o !== 1'b0) begin n_err++; $display("FAIL drop_one_cycle: got %b want 0", glu_drop_o); end

        doc_rd_i = 1'b1; doc_addr_i = 16'h0200;
        tick();
        doc_rd_i = 1'b0;
        mem_ack(0, 32'h0);   // completes the in-flight first write

        wait_issue(got);
        n_cmp++; if (!got || mem_wr_o !== 1'b1 || mem_addr_o !== 21'h10010 || mem_data_o !== 32'hA1A1A1A1 || mem_byte_en_o !== 4'b0010) begin
            n_err++; $display("FAIL full_wr_first: got wr=%b rd=%b addr=%h data=%h be=%b want wr=1 addr=10010 data=a1a1a1a1 be=0010",
                              mem_wr_o, mem_rd_o, mem_addr_o, mem_data_o, mem_byte_en_o); end
        n_cmp++; if (glu_full_o !== 1'b0) begin n_err++; $display("FAIL full_clear: got %b want 0", glu_full_o); end
        mem_ack(1, 32'h0);

        wait_issue(got);
        n_cmp++; if (!got || mem_rd_o !== 1'b1 || mem_addr_o !== 21'h10080) begin
            n_err++; $display("FAIL full_rd_next: got rd=%b addr=%h want rd=1 addr=10080", mem_rd_o, mem_addr_o); end
        mem_ack(1, 32'h0);

        for (int i = 0; i < 3; i++) begin
            wait_issue(got);
            n_cmp++;
            if (!got || mem_wr_o !== 1'b1 || mem_addr_o !== addr_tab[i] || mem_data_o !== {4{8'hA2 + 8'(i)}} || mem_byte_en_o !== be_tab[i]) begin
                n_err++; $display("FAIL full_drain%0d: got wr=%b addr=%h data=%h be=%b want addr=%h be=%b",
                                  i, mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o, addr_tab[i], be_tab[i]); end
            mem_ack(1, 32'h0);
        end

        extra = 0;
        repeat (8) begin
            tick();
            if (mem_wr_o || mem_rd_o) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL dropped_not_issued: got %0d issues want 0", extra); end
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        doc_rd_i = 1'b1; doc_addr_i = 16'h0006;
        tick();
        doc_rd_i = 1'b0;
        n_cmp++; if (mem_rd_o !== 1'b1) begin n_err++; $display("FAIL tmo_issue: mem_rd_o got %b want 1", mem_rd_o); end
        seen = 1'b0;
        for (n = 1; n <= 300; n++) begin
            tick();
            if (doc_ready_o) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL tmo_ready: no doc_ready_o within 300 cycles"); end
        n_cmp++; if (seen && n != 255) begin n_err++; $display("FAIL tmo_cycles: got %0d want 255", n); end
        n_cmp++; if (doc_data_o !== 8'h80) begin n_err++; $display("FAIL tmo_data: got %h want 80", doc_data_o); end
        n_cmp++; if (timeout_cnt_o !== 8'd1) begin n_err++; $display("FAIL tmo_count: got %0d want 1", timeout_cnt_o); end
        $display("read addr=0006 timed out, data=%h count=%0d", doc_data_o, timeout_cnt_o);

        doc_rd_i = 1'b1; doc_addr_i = 16'h0004;
        tick();
        doc_rd_i = 1'b0;
        n_cmp++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 21'h10001) begin
            n_err++; $display("FAIL tmo_next_issue: got rd=%b addr=%h want rd=1 addr=10001", mem_rd_o, mem_addr_o); end
        mem_ack(2, 32'h44332211);
        n_cmp++; if (doc_ready_o !== 1'b1 || doc_data_o !== 8'h11) begin
            n_err++; $display("FAIL tmo_next_data: got ready=%b data=%h want ready=1 data=11", doc_ready_o, doc_data_o); end
        n_cmp++; if (timeout_cnt_o !== 8'd1) begin n_err++; $display("FAIL tmo_count_hold: got %0d want 1", timeout_cnt_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        int spurious;
        doc_rd_i = 1'b1; doc_addr_i = 16'h0301;
        tick();
        doc_rd_i = 1'b0;
        n_cmp++; if (mem_rd_o !== 1'b1) begin n_err++; $display("FAIL rst_issue: mem_rd_o got %b want 1", mem_rd_o); end
        tick();
        system_reset_n = 1'b0;
        repeat (2) tick();
        system_reset_n = 1'b1;
        tick();
        mem_q_i = 32'hFFEEDDCC;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        spurious = 0;
        repeat (4) begin
            if (doc_ready_o || mem_rd_o || mem_wr_o) spurious++;
            tick();
        end
        n_cmp++; if (spurious !== 0) begin n_err++; $display("FAIL rst_stray_ready: got %0d pulses want 0", spurious); end
        n_cmp++; if (mem_addr_o !== 21'h0 || mem_byte_en_o !== 4'b1111 || mem_data_o !== 32'h0) begin
            n_err++; $display("FAIL rst_mem_outs: got addr=%h be=%b data=%h want 0/1111/0", mem_addr_o, mem_byte_en_o, mem_data_o); end
        n_cmp++; if (doc_data_o !== 8'h0 || timeout_cnt_o !== 8'h0 || glu_full_o !== 1'b0 || glu_drop_o !== 1'b0) begin
            n_err++; $display("FAIL rst_other_outs: got data=%h tmo=%0d full=%b drop=%b want 0", doc_data_o, timeout_cnt_o, glu_full_o, glu_drop_o); end
        $display("reset during read, stray ready ignored");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_order();
        test_full();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
